// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencing controller: states,
// opcodes, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EX     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EX     = 4'd11,
    S_I_WB     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_RT     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // First execution state for a freshly decoded opcode; unknown opcodes trap.
  function automatic state_t dispatch(input logic [5:0] op);
    state_t st;
    case (op)
      OP_LW, OP_SW:   st = S_MEM_ADDR;
      OP_R:           st = S_R_EX;
      OP_BEQ, OP_BNE: st = S_BRANCH;
      OP_J:           st = S_JUMP;
      OP_ADDI:        st = S_I_EX;
      default:        st = S_TRAP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the sequencing controller (master) and the datapath
// (slave): opcode and memory handshake in, all selects/enables out.
interface multicycle_ctrl_if;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       pc_write_cond_o;
  logic       branch_type_o;
  logic [1:0] pc_source_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       reg_write_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] alu_op_o;
  logic       retire_o;
  logic       illegal_o;
  logic [3:0] state_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, branch_type_o, pc_source_o,
           i_or_d_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o,
           mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
           retire_o, illegal_o, state_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, branch_type_o, pc_source_o,
           i_or_d_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o,
           mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
           retire_o, illegal_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_next_state.sv
// Next-state logic of the multi-cycle controller. Reset is applied by the
// state register in the top level, not here.
module mc_ctrl_next_state
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output state_t     next_state
);

  // Transition table; memory states wait for the ready handshake.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i) next_state = S_DECODE;
        else             next_state = S_FETCH;
      end
      S_DECODE:   next_state = dispatch(opcode_i);
      S_MEM_ADDR: begin
        if (op_q == OP_LW) next_state = S_MEM_RD;
        else               next_state = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready_i) next_state = S_MEM_WB;
        else             next_state = S_MEM_RD;
      end
      S_MEM_WB:   next_state = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready_i) next_state = S_FETCH;
        else             next_state = S_MEM_WR;
      end
      S_R_EX:     next_state = S_R_WB;
      S_R_WB:     next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_I_EX:     next_state = S_I_WB;
      S_I_WB:     next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset sequencing controller. Holds the state register,
// the latched opcode and the sticky illegal flag; decodes datapath controls
// from the current state (plus mem_ready in FETCH for the IR/PC load).
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  multicycle_ctrl_if.master   bus
);

  state_t     state_r;
  state_t     next_state_s;
  logic [5:0] op_q_r;
  logic       illegal_r;

  logic       pc_write_s, pc_write_cond_s, branch_type_s, i_or_d_s;
  logic       mem_read_s, mem_write_s, ir_write_s, reg_dst_s;
  logic       mem_to_reg_s, reg_write_s, alu_src_a_s, retire_s;
  logic [1:0] pc_source_s, alu_src_b_s, alu_op_s;

  mc_ctrl_next_state u_next_state (
    .state       (state_r),
    .op_q        (op_q_r),
    .opcode_i    (bus.opcode_i),
    .mem_ready_i (bus.mem_ready_i),
    .next_state  (next_state_s)
  );

  // State register, DECODE-time opcode latch and sticky illegal flag.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r   <= S_IDLE;
      op_q_r    <= 6'd0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_DECODE) op_q_r <= bus.opcode_i;
      if (next_state_s == S_TRAP) illegal_r <= 1'b1;
    end
  end

  // Per-state control decode; strobes and retire are squashed during reset.
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    branch_type_s   = 1'b0;
    pc_source_s     = PC_SRC_ALU;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_dst_s       = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = SRC_B_RT;
    alu_op_s        = ALU_OP_ADD;
    retire_s        = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = SRC_B_FOUR;
        ir_write_s  = bus.mem_ready_i;
        pc_write_s  = bus.mem_ready_i;
      end
      S_DECODE:   alu_src_b_s = SRC_B_IMM_SH;
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRC_B_IMM;
      end
      S_MEM_RD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
      end
      S_R_EX: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = ALU_OP_SUB;
        pc_write_cond_s = 1'b1;
        pc_source_s     = PC_SRC_ALUOUT;
        branch_type_s   = op_q_r[0];
      end
      S_JUMP: begin
        pc_write_s  = 1'b1;
        pc_source_s = PC_SRC_JUMP;
      end
      S_I_EX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRC_B_IMM;
      end
      S_I_WB:     reg_write_s = 1'b1;
      default:    ;
    endcase
    if (!rst_i) begin
      pc_write_s      = 1'b0;
      pc_write_cond_s = 1'b0;
      ir_write_s      = 1'b0;
      mem_read_s      = 1'b0;
      mem_write_s     = 1'b0;
      reg_write_s     = 1'b0;
      retire_s        = 1'b0;
    end else begin
      // An instruction completes when it hands back to FETCH; the reset
      // start-up (IDLE) and a stalled fetch do not count.
      retire_s = (next_state_s == S_FETCH) && (state_r != S_IDLE) &&
                 (state_r != S_FETCH);
    end
  end

  assign bus.pc_write_o      = pc_write_s;
  assign bus.pc_write_cond_o = pc_write_cond_s;
  assign bus.branch_type_o   = branch_type_s;
  assign bus.pc_source_o     = pc_source_s;
  assign bus.i_or_d_o        = i_or_d_s;
  assign bus.mem_read_o      = mem_read_s;
  assign bus.mem_write_o     = mem_write_s;
  assign bus.ir_write_o      = ir_write_s;
  assign bus.reg_dst_o       = reg_dst_s;
  assign bus.mem_to_reg_o    = mem_to_reg_s;
  assign bus.reg_write_o     = reg_write_s;
  assign bus.alu_src_a_o     = alu_src_a_s;
  assign bus.alu_src_b_o     = alu_src_b_s;
  assign bus.alu_op_o        = alu_op_s;
  assign bus.retire_o        = retire_s;
  assign bus.illegal_o       = illegal_r;
  assign bus.state_o         = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. The stimulus walks whole
// instructions as lists of spec-level steps; a model turns each step into
// the full expected control vector, compared on every negative edge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_type;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
    logic       illegal;
    logic [3:0] state;
  } ctl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  ctl_t       dut_vec;
  ctl_t       exp_vec;
  logic       exp_valid = 1'b0;
  logic [5:0] opq_m = 6'd0;
  int         checks = 0;
  int         failures = 0;
  int         retire_seen = 0;

  assign dut_vec = '{bus.pc_write_o, bus.pc_write_cond_o, bus.branch_type_o,
                     bus.pc_source_o, bus.i_or_d_o, bus.mem_read_o,
                     bus.mem_write_o, bus.ir_write_o, bus.reg_dst_o,
                     bus.mem_to_reg_o, bus.reg_write_o, bus.alu_src_a_o,
                     bus.alu_src_b_o, bus.alu_op_o, bus.retire_o,
                     bus.illegal_o, bus.state_o};

  // Spec table: what each state asserts, given ready/reset and whether
  // this step is the last one of its instruction.
  function automatic ctl_t model(input int st, input logic [5:0] opq,
                                 input logic rdy, input logic rstv,
                                 input logic last);
    ctl_t c;
    c = '0;
    c.state = 4'(st);
    case (st)
      1: begin c.mem_read = 1'b1; c.alu_src_b = 2'b01;
               c.ir_write = rdy; c.pc_write = rdy; end
      2: c.alu_src_b = 2'b11;
      3: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4: begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      5: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      6: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      7: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      8: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      9: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
               c.pc_source = 2'b01; c.branch_type = opq[0]; end
      10: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      11: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      12: c.reg_write = 1'b1;
      13: c.illegal = 1'b1;
      default: ;
    endcase
    c.retire = last;
    if (!rstv) begin
      c.pc_write = 1'b0; c.pc_write_cond = 1'b0; c.ir_write = 1'b0;
      c.mem_read = 1'b0; c.mem_write = 1'b0; c.reg_write = 1'b0;
      c.retire = 1'b0;
    end
    return c;
  endfunction

  // Every-cycle comparison of the DUT control vector against the model.
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL cyc_vec t=%0t state=%0d got=%h want=%h", $time,
                 exp_vec.state, dut_vec, exp_vec);
      end
      if (bus.retire_o === 1'b1) retire_seen++;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // One clock of stimulus with its expected outputs.
  task automatic cyc(input int st, input logic rdy, input logic rstv,
                     input logic last);
    bus.mem_ready_i = rdy;
    rst = rstv;
    exp_vec = model(st, opq_m, rdy, rstv, last);
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Walks one instruction from FETCH to its hand-back; returns cycle count.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           output int n);
    n = 0;
    for (int i = 0; i < fw; i++) begin cyc(1, 1'b0, 1'b1, 1'b0); n++; end
    cyc(1, 1'b1, 1'b1, 1'b0); n++;
    bus.opcode_i = op;
    opq_m = op;
    cyc(2, 1'b0, 1'b1, 1'b0); n++;
    bus.opcode_i = 6'h2A;
    case (op)
      6'h00: begin cyc(7, 1'b0, 1'b1, 1'b0); cyc(8, 1'b0, 1'b1, 1'b1); n += 2; end
      6'h08: begin cyc(11, 1'b1, 1'b1, 1'b0); cyc(12, 1'b0, 1'b1, 1'b1); n += 2; end
      6'h23: begin
        cyc(3, 1'b0, 1'b1, 1'b0); n++;
        for (int i = 0; i < mw; i++) begin cyc(4, 1'b0, 1'b1, 1'b0); n++; end
        cyc(4, 1'b1, 1'b1, 1'b0); cyc(5, 1'b0, 1'b1, 1'b1); n += 2;
      end
      6'h2B: begin
        cyc(3, 1'b1, 1'b1, 1'b0); n++;
        for (int i = 0; i < mw; i++) begin cyc(6, 1'b0, 1'b1, 1'b0); n++; end
        cyc(6, 1'b1, 1'b1, 1'b1); n++;
      end
      6'h04, 6'h05: begin cyc(9, 1'b1, 1'b1, 1'b1); n++; end
      6'h02: begin cyc(10, 1'b0, 1'b1, 1'b1); n++; end
      default: ;
    endcase
  endtask

  initial begin
    int n;
    bus.opcode_i = 6'h00;
    bus.mem_ready_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    // Reset held a second cycle, then released: one IDLE cycle.
    cyc(0, 1'b1, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b1, 1'b0);

    run_instr(6'h00, 0, 0, n); chk("lat_r", n, 4);
    run_instr(6'h23, 0, 3, n); chk("lat_lw_wait", n, 8);
    run_instr(6'h2B, 0, 0, n); chk("lat_sw", n, 4);
    run_instr(6'h04, 0, 0, n); chk("lat_beq", n, 3);
    run_instr(6'h05, 0, 0, n); chk("lat_bne", n, 3);
    run_instr(6'h02, 0, 0, n); chk("lat_j", n, 3);
    run_instr(6'h08, 2, 0, n); chk("lat_addi_fwait", n, 6);
    run_instr(6'h23, 0, 0, n); chk("lat_lw", n, 5);

    // sw aborted by reset while waiting in MEM_WR.
    cyc(1, 1'b1, 1'b1, 1'b0);
    bus.opcode_i = 6'h2B; opq_m = 6'h2B;
    cyc(2, 1'b0, 1'b1, 1'b0);
    bus.opcode_i = 6'h00;
    cyc(3, 1'b0, 1'b1, 1'b0);
    cyc(6, 1'b0, 1'b1, 1'b0);
    cyc(6, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b0);
    run_instr(6'h04, 0, 0, n); chk("lat_beq_after_abort", n, 3);

    // Illegal opcode: trap until reset, ready ignored.
    run_instr(6'h3F, 0, 0, n);
    for (int i = 0; i < 12; i++) cyc(13, 1'(i % 2), 1'b1, 1'b0);
    cyc(13, 1'b1, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b0);
    cyc(1, 1'b0, 1'b1, 1'b0);
    exp_valid = 1'b0;

    chk("retire_count", retire_seen, 9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
